// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the unified SRAM port arbiter.
// Port indices, in-flight tag layout and legal read-latency range.
package sram_arb_pkg;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int MEM_RD_LAT_MIN = 1;
   localparam int MEM_RD_LAT_MAX = 2;

   typedef struct packed {
      logic valid;
      logic port;
   } arb_tag_t;

   localparam arb_tag_t TAG_NONE = '{valid: 1'b0, port: PORT_I};

   function automatic int clamp_lat(input int lat);
      if (lat < MEM_RD_LAT_MIN) return MEM_RD_LAT_MIN;
      if (lat > MEM_RD_LAT_MAX) return MEM_RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_tag_pipe.sv
// arb_tag_pipe: shift register of {valid, port} tags, one per grant.
// The oldest tag is exposed; a synchronous clear drops everything.
module arb_tag_pipe
   import sram_arb_pkg::*;
#(
   parameter int DEPTH = 1
)
(
   input  logic     clk,
   input  logic     i_clr,
   input  arb_tag_t i_tag,
   output arb_tag_t o_tag
);

   arb_tag_t r_tags [DEPTH];

   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tags[i] <= TAG_NONE;
         end
      end else begin
         r_tags[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_tags[i] <= r_tags[i-1];
         end
      end
   end

   assign o_tag = r_tags[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM between instruction fetch and load/store.
// Define SRAM_ARB_RR_EN for round-robin; default is data-over-instruction.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int MEM_RD_LAT = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [3:0]  d_wstrb,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int LAT = clamp_lat(MEM_RD_LAT);

   logic     w_i_win;
   logic     w_d_win;
   logic     w_grant;
   logic     w_rsp_ok;
   arb_tag_t w_tag_in;
   arb_tag_t w_tag_out;

`ifdef SRAM_ARB_RR_EN
   logic r_last;

   // Pointer follows every grant so an idle port wins the next conflict
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= PORT_I;
      end else if (w_grant) begin
         r_last <= w_d_win ? PORT_D : PORT_I;
      end
   end

   always_comb begin
      w_d_win = 1'b0;
      if (!reset) begin
         if (i_req && d_req) begin
            w_d_win = (r_last == PORT_I);
         end else begin
            w_d_win = d_req;
         end
      end
   end
`else
   always_comb begin
      w_d_win = !reset && d_req;
   end
`endif

   assign w_i_win = !reset && i_req && !w_d_win;
   assign w_grant = w_i_win || w_d_win;

   assign i_addr_ok = w_i_win;
   assign d_addr_ok = w_d_win;

   assign mem_en    = w_grant;
   assign mem_we    = (w_d_win && d_wr) ? d_wstrb : 4'b0000;
   assign mem_addr  = w_d_win ? d_addr :
                      (w_i_win ? i_addr : 32'h0);
   assign mem_wdata = w_d_win ? d_wdata : 32'h0;

   assign w_tag_in = '{
      valid: w_grant,
      port:  (w_d_win ? PORT_D : PORT_I)
   };

   arb_tag_pipe #(
      .DEPTH (LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .i_clr (reset),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   // Tags exiting while reset is high belong to discarded grants
   assign w_rsp_ok  = w_tag_out.valid && !reset;
   assign i_data_ok = w_rsp_ok && (w_tag_out.port == PORT_I);
   assign d_data_ok = w_rsp_ok && (w_tag_out.port == PORT_D);

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (latency 1 and 2) share stimulus.
// A queue-based reference model checks every cycle; literals pin key cases.
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'h0;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [3:0]  d_wstrb = 4'h0;
   logic [31:0] d_addr = 32'h0;
   logic [31:0] d_wdata = 32'h0;

   logic        iaok [2];
   logic        iok [2];
   logic        daok [2];
   logic        dok [2];
   logic        men [2];
   logic [3:0]  mwe [2];
   logic [31:0] irdata [2];
   logic [31:0] drdata [2];
   logic [31:0] maddr [2];
   logic [31:0] mwdata [2];
   logic [31:0] mrdata [2];

   logic [31:0] mem [2][256];
   logic [31:0] ref_mem [2][256];
   logic [31:0] dl [2][2];

   int cyc = 0;
   int scene = 0;
   int scene_next = 0;
   int s0 = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_port_arbiter #(
         .MEM_RD_LAT (g + 1)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .i_req     (i_req),
         .i_addr    (i_addr),
         .i_addr_ok (iaok[g]),
         .i_data_ok (iok[g]),
         .i_rdata   (irdata[g]),
         .d_req     (d_req),
         .d_wr      (d_wr),
         .d_wstrb   (d_wstrb),
         .d_addr    (d_addr),
         .d_wdata   (d_wdata),
         .d_addr_ok (daok[g]),
         .d_data_ok (dok[g]),
         .d_rdata   (drdata[g]),
         .mem_en    (men[g]),
         .mem_we    (mwe[g]),
         .mem_addr  (maddr[g]),
         .mem_wdata (mwdata[g]),
         .mem_rdata (mrdata[g])
      );
      assign mrdata[g] = dl[g][g];
   end

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = i[7:0];
      return (i == 0) ? 32'h02800421 : {8'hA5, b, ~b, b};
   endfunction

   // SRAM behaviour: read-before-write, data delayed by the instance latency
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int ix;
         ix = int'(maddr[k][9:2]);
         dl[k][1] <= dl[k][0];
         if (men[k]) begin
            dl[k][0] <= mem[k][ix];
            for (int b = 0; b < 4; b++) begin
               if (mwe[k][b]) mem[k][ix][8*b +: 8] = mwdata[k][8*b +: 8];
            end
         end else begin
            dl[k][0] <= 32'h0;
         end
      end
   end

   typedef struct {
      int          inst;
      int          due;
      logic        port;
      logic        wr;
      logic [31:0] data;
   } rsp_t;

   rsp_t q[$];
   logic last [2];

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lat%0d cyc%0d: got %h want %h",
                  nm, k + 1, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int rel;
      for (int k = 0; k < 2; k++) begin
         logic eg, ep, e_iok, e_dok, ewr;
         logic [31:0] e_rd, a, w;
         int fi, ix;
         if (reset) begin
            for (int j = q.size() - 1; j >= 0; j--) begin
               if (q[j].inst == k) q.delete(j);
            end
            last[k] = PORT_I;
         end
         e_iok = 1'b0;
         e_dok = 1'b0;
         ewr = 1'b0;
         e_rd = 32'h0;
         fi = -1;
         for (int j = 0; j < q.size(); j++) begin
            if (fi < 0 && q[j].inst == k) fi = j;
         end
         if (fi >= 0 && q[fi].due == cyc) begin
            e_iok = (q[fi].port == PORT_I);
            e_dok = !e_iok;
            e_rd = q[fi].data;
            ewr = q[fi].wr;
            q.delete(fi);
         end
         chk("i_data_ok", k, 32'(iok[k]), 32'(e_iok));
         chk("d_data_ok", k, 32'(dok[k]), 32'(e_dok));
         if (e_iok) chk("i_rdata", k, irdata[k], e_rd);
         if (e_dok && !ewr) chk("d_rdata", k, drdata[k], e_rd);

         eg = !reset && (i_req || d_req);
         if (i_req && d_req) ep = RR ? ~last[k] : PORT_D;
         else ep = d_req;
         chk("i_addr_ok", k, 32'(iaok[k]), 32'(eg && !ep));
         chk("d_addr_ok", k, 32'(daok[k]), 32'(eg && ep));
         chk("mem_en", k, 32'(men[k]), 32'(eg));
         chk("mem_we", k, 32'(mwe[k]),
             32'((eg && ep && d_wr) ? d_wstrb : 4'h0));
         chk("mem_addr", k, maddr[k],
             !eg ? 32'h0 : (ep ? d_addr : i_addr));
         chk("mem_wdata", k, mwdata[k],
             (eg && ep) ? d_wdata : 32'h0);
         if (eg) begin
            a = ep ? d_addr : i_addr;
            ix = int'(a[9:2]);
            w = ref_mem[k][ix];
            if (ep && d_wr) begin
               for (int b = 0; b < 4; b++) begin
                  if (d_wstrb[b]) ref_mem[k][ix][8*b +: 8] = d_wdata[8*b +: 8];
               end
            end
            q.push_back('{inst: k, due: cyc + k + 1, port: ep,
                          wr: (ep && d_wr), data: w});
            last[k] = ep;
         end
      end

      rel = cyc - s0;
      case (scene)
         1: if (rel == 1) begin
               chk("rst_mem_en", 0, 32'(men[0]), 32'h0);
               chk("rst_d_addr_ok", 1, 32'(daok[1]), 32'h0);
            end
         2: if (rel == 3) begin
               chk("idle_mem_en", 1, 32'(men[1]), 32'h0);
               chk("idle_d_data_ok", 0, 32'(dok[0]), 32'h0);
            end
         3: begin
               if (rel == 0) begin
                  chk("ird_addr_ok", 0, 32'(iaok[0]), 32'h1);
                  chk("ird_mem_we", 0, 32'(mwe[0]), 32'h0);
                  chk("ird_mem_addr", 0, maddr[0], 32'h1c000000);
               end
               if (rel == 1) begin
                  chk("ird_data_ok", 0, 32'(iok[0]), 32'h1);
                  chk("ird_rdata", 0, irdata[0], 32'h02800421);
               end
               if (rel == 2) chk("ird_rdata", 1, irdata[1], 32'h02800421);
            end
         4: begin
               if (rel == 0) chk("cfl_c0_d", 0, 32'(daok[0]), 32'h1);
               if (rel == 1) chk("cfl_c1_d", 0, 32'(daok[0]), RR ? 32'h0 : 32'h1);
               if (rel == 3) chk("cfl_c3_i", 0, 32'(iaok[0]), 32'h1);
            end
         5: begin
               if (rel == 0) begin
                  chk("wr_mem_we", 0, 32'(mwe[0]), 32'h3);
                  chk("wr_mem_addr", 0, maddr[0], 32'h100);
                  chk("wr_mem_wdata", 0, mwdata[0], 32'hdeadbeef);
               end
               if (rel == 1) begin
                  chk("wr_d_data_ok", 0, 32'(dok[0]), 32'h1);
                  chk("wr_i_data_ok", 0, 32'(iok[0]), 32'h0);
               end
               if (rel == 2) begin
                  chk("wr_d_data_ok", 1, 32'(dok[1]), 32'h1);
                  chk("wr_readback", 0, drdata[0], 32'hA540BEEF);
               end
            end
         6: begin
               if (rel == 2) chk("b2b_rd0", 1, irdata[1], 32'hA502FD02);
               if (rel == 3) chk("b2b_rd1", 1, irdata[1], 32'hA503FC03);
               if (rel == 4) chk("b2b_rd2", 1, irdata[1], 32'hA504FB04);
               if (rel >= 2 && rel <= 4) chk("b2b_ok", 1, 32'(iok[1]), 32'h1);
            end
         7: begin
               if (rel == 1) begin
                  chk("rmf_i_data_ok", 0, 32'(iok[0]), 32'h0);
                  chk("rmf_mem_en", 0, 32'(men[0]), 32'h0);
               end
               if (rel == 2) chk("rmf_i_data_ok", 1, 32'(iok[1]), 32'h0);
               if (rel == 3) begin
                  chk("rmf_first_cfl_d", 0, 32'(daok[0]), 32'h1);
                  chk("rmf_i_data_ok", 1, 32'(iok[1]), 32'h0);
               end
            end
         default: ;
      endcase
   end

   task automatic drv(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit wr, input logic [3:0] st,
                      input logic [31:0] da, input logic [31:0] wd);
      @(posedge clk);
      #1;
      if (scene_next != 0) begin
         scene = scene_next;
         s0 = cyc;
         scene_next = 0;
      end
      reset = rst;
      i_req = ir;
      i_addr = ia;
      d_req = dr;
      d_wr = wr;
      d_wstrb = st;
      d_addr = da;
      d_wdata = wd;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         last[k] = PORT_I;
         for (int i = 0; i < 256; i++) begin
            mem[k][i] = init_word(i);
            ref_mem[k][i] = init_word(i);
         end
      end

      scene_next = 1;
      repeat (3) drv(1'b1, 1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);

      scene_next = 2;
      idle(4);

      scene_next = 3;
      drv(1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(3);

      scene_next = 4;
      repeat (3) drv(1'b0, 1'b1, 32'h1c000004, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
      drv(1'b0, 1'b1, 32'h1c000004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(3);

      scene_next = 5;
      drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hdeadbeef);
      drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
      idle(3);

      scene_next = 6;
      drv(1'b0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1'b0, 1'b1, 32'h1c00000c, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1'b0, 1'b1, 32'h1c000010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(4);

      scene_next = 8;
      drv(1'b0, 1'b1, 32'h1c000014, 1'b1, 1'b1, 4'b1111, 32'h204, 32'h11223344);
      drv(1'b0, 1'b1, 32'h1c000014, 1'b1, 1'b0, 4'h0, 32'h204, 32'h0);
      drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b1000, 32'h204, 32'haa000000);
      drv(1'b0, 1'b1, 32'h1c000018, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1'b0, 1'b1, 32'h1c00001c, 1'b1, 1'b0, 4'h0, 32'h208, 32'h0);
      idle(1);
      drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h204, 32'h0);
      drv(1'b0, 1'b1, 32'h1c000020, 1'b1, 1'b1, 4'b0100, 32'h0, 32'h00550000);
      drv(1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(3);

      scene_next = 7;
      drv(1'b0, 1'b1, 32'h1c000014, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv(1'b0, 1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h208, 32'h0);
      idle(4);

      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
